// File: rtl/frac_decim_coeff_sequencer.sv
// Coefficient reload sequencer for the single-MAC fractional decimator: blocks input,
// drains the MAC, streams a new coefficient set, then refills the delay line before passing output.
module frac_decim_coeff_sequencer #(
    parameter int unsigned DataWidth      = 18,
    parameter int unsigned CoeffWidth     = 18,
    parameter int unsigned CoeffAddrWidth = 4,
    parameter int unsigned DrainCycles    = 8,
    parameter int unsigned FlushSamples   = 16
) (
    input  logic                      Clk_i,
    input  logic                      Rst_i,
    input  logic                      Load_i,
    input  logic [CoeffAddrWidth-1:0] LoadLen_i,
    input  logic [CoeffWidth-1:0]     CoeffData_i,
    input  logic                      CoeffValid_i,
    output logic                      CoeffReady_o,
    input  logic [DataWidth-1:0]      Data_i,
    input  logic                      DataNd_i,
    input  logic [DataWidth-1:0]      DecData_i,
    input  logic                      DecValid_i,
    output logic [DataWidth-1:0]      DataFwd_o,
    output logic                      DataNdFwd_o,
    output logic [CoeffAddrWidth-1:0] CoeffAddr_o,
    output logic [CoeffWidth-1:0]     CoeffData_o,
    output logic                      CoeffWr_o,
    output logic [DataWidth-1:0]      Data_o,
    output logic                      DataValid_o,
    output logic                      Busy_o,
    output logic                      LoadErr_o,
    output logic [15:0]               DropCnt_o
);

    localparam int unsigned LenW   = CoeffAddrWidth + 1;
    localparam int unsigned DrainW = $clog2(DrainCycles + 1);
    localparam int unsigned FlushW = $clog2(FlushSamples + 1);

    typedef enum logic [2:0] {StCfgWait, StDrain, StLoad, StFlush, StRun} state_e;

    state_e                    r_state, w_state_nxt;
    logic [LenW-1:0]           r_len, r_idx;
    logic [DrainW-1:0]         r_drain_cnt;
    logic [FlushW-1:0]         r_flush_cnt;
    logic                      r_ready, r_busy, r_err, r_wr, r_nd_fwd, r_dv;
    logic [CoeffAddrWidth-1:0] r_addr;
    logic [CoeffWidth-1:0]     r_cdata;
    logic [DataWidth-1:0]      r_data_fwd, r_dout;
    logic [15:0]               r_drop_cnt;

    logic            w_beat, w_fwd_en, w_run, w_load_err, w_load_acc;
    logic [LenW-1:0] w_len_load;

    // A zero length encodes the full 2^CoeffAddrWidth table.
    assign w_len_load = {(LoadLen_i == '0), LoadLen_i};
    assign w_beat     = r_ready & CoeffValid_i;
    assign w_fwd_en   = (r_state == StFlush) || (r_state == StRun);
    assign w_run      = (r_state == StRun);

    always_comb begin
        w_state_nxt = r_state;
        w_load_err  = 1'b0;
        w_load_acc  = 1'b0;
        case (r_state)
            StCfgWait: begin
                if (Load_i) begin
                    w_state_nxt = StLoad;
                    w_load_acc  = 1'b1;
                end
            end
            StDrain: begin
                w_load_err = Load_i;
                if (r_drain_cnt == DrainW'(DrainCycles - 1)) w_state_nxt = StLoad;
            end
            StLoad: begin
                w_load_err = Load_i;
                if (w_beat && (r_idx == r_len - 1'b1)) w_state_nxt = StFlush;
            end
            StFlush, StRun: begin
                if (Load_i) begin
                    w_state_nxt = StDrain;
                    w_load_acc  = 1'b1;
                end else if (r_state == StFlush && DataNd_i &&
                             r_flush_cnt == FlushW'(FlushSamples - 1)) begin
                    w_state_nxt = StRun;
                end
            end
            default: w_state_nxt = StCfgWait;
        endcase
    end

    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i) begin
            r_state     <= StCfgWait;
            r_len       <= '0;
            r_idx       <= '0;
            r_drain_cnt <= '0;
            r_flush_cnt <= '0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_wr        <= 1'b0;
            r_addr      <= '0;
            r_cdata     <= '0;
            r_nd_fwd    <= 1'b0;
            r_data_fwd  <= '0;
            r_dv        <= 1'b0;
            r_dout      <= '0;
            r_drop_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == StLoad);
            r_busy  <= (w_state_nxt == StDrain) || (w_state_nxt == StLoad);
            r_err   <= w_load_err;
            if (w_load_acc) r_len <= w_len_load;

            // Counters stay cleared outside their own state, so entry always starts from zero.
            r_drain_cnt <= (r_state == StDrain) ? r_drain_cnt + 1'b1 : '0;
            if (r_state != StLoad)   r_idx <= '0;
            else if (w_beat)         r_idx <= r_idx + 1'b1;
            if (r_state != StFlush)  r_flush_cnt <= '0;
            else if (DataNd_i)       r_flush_cnt <= r_flush_cnt + 1'b1;

            r_wr <= w_beat;
            if (w_beat) begin
                r_addr  <= r_idx[CoeffAddrWidth-1:0];
                r_cdata <= CoeffData_i;
            end

            r_nd_fwd <= w_fwd_en & DataNd_i;
            if (w_fwd_en) r_data_fwd <= Data_i;
            else if (DataNd_i && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 1'b1;

            r_dv <= w_run & DecValid_i;
            if (w_run) r_dout <= DecData_i;
        end
    end

    assign CoeffReady_o = r_ready;
    assign CoeffWr_o    = r_wr;
    assign CoeffAddr_o  = r_addr;
    assign CoeffData_o  = r_cdata;
    assign DataNdFwd_o  = r_nd_fwd;
    assign DataFwd_o    = r_data_fwd;
    assign DataValid_o  = r_dv;
    assign Data_o       = r_dout;
    assign Busy_o       = r_busy;
    assign LoadErr_o    = r_err;
    assign DropCnt_o    = r_drop_cnt;

endmodule

// File: tb/tb_frac_decim_coeff_sequencer.sv
// Randomized bench for frac_decim_coeff_sequencer with a phase/remaining-count reference model
// compared every cycle, plus directed scenarios pinned by literal expectations.
module tb_frac_decim_coeff_sequencer;

    localparam int DW = 18;
    localparam int CW = 18;
    localparam int AW = 4;
    localparam int DC = 8;
    localparam int FS = 16;

    logic          Clk_i = 1'b0;
    logic          Rst_i, Load_i, CoeffValid_i, DataNd_i, DecValid_i;
    logic [AW-1:0] LoadLen_i;
    logic [CW-1:0] CoeffData_i;
    logic [DW-1:0] Data_i, DecData_i;
    logic          CoeffReady_o, DataNdFwd_o, CoeffWr_o, DataValid_o, Busy_o, LoadErr_o;
    logic [DW-1:0] DataFwd_o, Data_o;
    logic [AW-1:0] CoeffAddr_o;
    logic [CW-1:0] CoeffData_o;
    logic [15:0]   DropCnt_o;

    frac_decim_coeff_sequencer #(
        .DataWidth(DW), .CoeffWidth(CW), .CoeffAddrWidth(AW),
        .DrainCycles(DC), .FlushSamples(FS)
    ) dut (
        .Clk_i(Clk_i), .Rst_i(Rst_i), .Load_i(Load_i), .LoadLen_i(LoadLen_i),
        .CoeffData_i(CoeffData_i), .CoeffValid_i(CoeffValid_i), .CoeffReady_o(CoeffReady_o),
        .Data_i(Data_i), .DataNd_i(DataNd_i), .DecData_i(DecData_i), .DecValid_i(DecValid_i),
        .DataFwd_o(DataFwd_o), .DataNdFwd_o(DataNdFwd_o), .CoeffAddr_o(CoeffAddr_o),
        .CoeffData_o(CoeffData_o), .CoeffWr_o(CoeffWr_o), .Data_o(Data_o),
        .DataValid_o(DataValid_o), .Busy_o(Busy_o), .LoadErr_o(LoadErr_o), .DropCnt_o(DropCnt_o)
    );

    always #5 Clk_i = ~Clk_i;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: spec phases with "remaining" counters.
    typedef enum {MCfg, MDrain, MLoad, MFlush, MRun} mode_e;
    mode_e       mode;
    int          m_drain_left, m_coef_left, m_flush_left, m_idx, m_len;
    int unsigned m_drop;
    logic          exp_ready, exp_nd, exp_wr, exp_dv, exp_busy, exp_err;
    logic [DW-1:0] exp_fwd, exp_do;
    logic [AW-1:0] exp_addr;
    logic [CW-1:0] exp_cdata;

    // Stimulus knobs and host coefficient source.
    int            cyc = 0;
    int            nd_period = 0;
    int            cv_mode = 1;
    bit            dec_always = 0;
    int            host_idx = 0;
    logic [CW-1:0] cq [64];

    // Observation log of DUT activity.
    logic [AW-1:0] wa[$];
    logic [CW-1:0] wd[$];
    int            err_pulses, fwd_before, first_wr_cyc;
    bit            seen_dv;

    function automatic int len_of(input logic [AW-1:0] l);
        return (l == 0) ? (1 << AW) : int'(l);
    endfunction

    task automatic model_reset();
        mode = MCfg;
        m_drain_left = 0; m_coef_left = 0; m_flush_left = 0; m_idx = 0; m_len = 0; m_drop = 0;
        exp_ready = 0; exp_nd = 0; exp_wr = 0; exp_dv = 0; exp_busy = 0; exp_err = 0;
        exp_fwd = '0; exp_do = '0; exp_addr = '0; exp_cdata = '0;
    endtask

    task automatic model_step();
        bit fwd, beat;
        fwd  = (mode == MFlush) || (mode == MRun);
        beat = (mode == MLoad) && CoeffValid_i;
        exp_nd = fwd && DataNd_i;
        if (fwd) exp_fwd = Data_i;
        else if (DataNd_i && m_drop < 65535) m_drop++;
        exp_dv = (mode == MRun) && DecValid_i;
        if (mode == MRun) exp_do = DecData_i;
        exp_err = Load_i && (mode == MDrain || mode == MLoad);
        exp_wr = beat;
        if (beat) begin
            exp_addr  = AW'(m_idx);
            exp_cdata = CoeffData_i;
            host_idx++;
        end
        case (mode)
            MCfg: if (Load_i) begin
                mode = MLoad; m_coef_left = len_of(LoadLen_i); m_idx = 0;
            end
            MRun, MFlush: begin
                if (Load_i) begin
                    m_len = len_of(LoadLen_i); mode = MDrain; m_drain_left = DC;
                end else if (mode == MFlush && DataNd_i) begin
                    m_flush_left--;
                    if (m_flush_left == 0) mode = MRun;
                end
            end
            MDrain: begin
                m_drain_left--;
                if (m_drain_left == 0) begin
                    mode = MLoad; m_coef_left = m_len; m_idx = 0;
                end
            end
            MLoad: if (beat) begin
                m_idx++; m_coef_left--;
                if (m_coef_left == 0) begin
                    mode = MFlush; m_flush_left = FS;
                end
            end
            default: ;
        endcase
        exp_ready = (mode == MLoad);
        exp_busy  = (mode == MDrain) || (mode == MLoad);
    endtask

    task automatic compare();
        chk("coeff_ready", CoeffReady_o, exp_ready);
        chk("coeff_wr", CoeffWr_o, exp_wr);
        chk("coeff_addr", CoeffAddr_o, exp_addr);
        chk("coeff_data", CoeffData_o, exp_cdata);
        chk("nd_fwd", DataNdFwd_o, exp_nd);
        chk("data_fwd", DataFwd_o, exp_fwd);
        chk("data_valid", DataValid_o, exp_dv);
        chk("data_out", Data_o, exp_do);
        chk("busy", Busy_o, exp_busy);
        chk("load_err", LoadErr_o, exp_err);
        chk("drop_cnt", DropCnt_o, m_drop[15:0]);
        if (CoeffWr_o) begin
            wa.push_back(CoeffAddr_o);
            wd.push_back(CoeffData_o);
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
        end
        if (LoadErr_o) err_pulses++;
        if (!seen_dv) begin
            if (DataValid_o) seen_dv = 1;
            else if (DataNdFwd_o) fwd_before++;
        end
    endtask

    task automatic drive();
        DataNd_i  = (nd_period == 0) ? 1'($urandom_range(0, 1)) : ((cyc % nd_period) == 0);
        Data_i    = DW'($urandom);
        DecValid_i = dec_always ? 1'b1 : 1'($urandom_range(0, 1));
        DecData_i = DW'($urandom);
        case (cv_mode)
            0: CoeffValid_i = 1'b0;
            1: CoeffValid_i = 1'b1;
            2: CoeffValid_i = (cyc % 2) == 0;
            default: CoeffValid_i = 1'($urandom_range(0, 1));
        endcase
        CoeffData_i = cq[host_idx % 64];
    endtask

    // One clock: drive at negedge, model at posedge, compare at the following negedge.
    task automatic cycle();
        drive();
        @(posedge Clk_i);
        cyc++;
        if (Rst_i) model_reset();
        else model_step();
        @(negedge Clk_i);
        compare();
    endtask

    task automatic clear_log();
        wa.delete(); wd.delete();
        err_pulses = 0; first_wr_cyc = -1;
    endtask

    task automatic start_load(input int len);
        host_idx = 0;
        Load_i = 1'b1;
        LoadLen_i = AW'(len);
        cycle();
        Load_i = 1'b0;
    endtask

    initial begin
        logic [CW-1:0] lit [3];
        int load_cyc, t;
        lit[0] = 18'h00001; lit[1] = 18'h00002; lit[2] = 18'h3FFFF;
        Rst_i = 1'b1; Load_i = 1'b0; LoadLen_i = '0; CoeffValid_i = 1'b0; CoeffData_i = '0;
        DataNd_i = 1'b0; Data_i = '0; DecValid_i = 1'b0; DecData_i = '0;
        for (int i = 0; i < 64; i++) cq[i] = CW'($urandom);
        model_reset();
        clear_log();
        @(negedge Clk_i);
        repeat (3) cycle();
        chk("reset_busy", Busy_o, 0);
        chk("reset_drop", DropCnt_o, 0);
        Rst_i = 1'b0;

        // Load of three back-to-back coefficients straight from CFG_WAIT.
        cq[0] = lit[0]; cq[1] = lit[1]; cq[2] = lit[2];
        cv_mode = 1; nd_period = 0; dec_always = 1;
        seen_dv = 0; fwd_before = 0;
        repeat (4) cycle();
        clear_log();
        start_load(3);
        repeat (6) cycle();
        chk("t1_nwr", wa.size(), 3);
        for (int i = 0; i < 3 && i < wa.size(); i++) begin
            chk("t1_addr", wa[i], i);
            chk("t1_data", wd[i], lit[i]);
        end

        // Refill: output stays gated until the 16th forwarded strobe.
        nd_period = 16;
        t = 0;
        while (!seen_dv && t < 400) begin cycle(); t++; end
        chk("t2_dv_seen", seen_dv, 1);
        chk("t2_fwd_before_valid", fwd_before, FS);
        dec_always = 0;
        repeat (20) cycle();

        // Reload from RUN: drain then load.
        clear_log();
        for (int i = 0; i < 64; i++) cq[i] = CW'($urandom);
        start_load(4);
        load_cyc = cyc;
        chk("t3_busy_next", Busy_o, 1);
        repeat (30) cycle();
        chk("t3_nwr", wa.size(), 4);
        chk("t3_latency_ok", (first_wr_cyc - load_cyc) >= DC + 1, 1);

        // Load while in LOAD is rejected exactly once and leaves the sequence intact.
        clear_log();
        cv_mode = 0;
        start_load(6);
        repeat (DC + 2) cycle();
        Load_i = 1'b1; LoadLen_i = 4'd2;
        cycle();
        Load_i = 1'b0;
        cv_mode = 2;
        repeat (40) cycle();
        chk("t4_err_pulses", err_pulses, 1);
        chk("t4_nwr", wa.size(), 6);
        for (int i = 0; i < 6 && i < wa.size(); i++) chk("t4_addr", wa[i], i);

        // Full 16-tap table with gapped valid.
        clear_log();
        start_load(0);
        repeat (DC + 45) cycle();
        chk("t5_nwr", wa.size(), 16);
        for (int i = 0; i < 16 && i < wa.size(); i++) begin
            chk("t5_addr", wa[i], i);
            chk("t5_data", wd[i], cq[i]);
        end

        // Async reset in the middle of a 5-coefficient load.
        clear_log();
        cv_mode = 1;
        start_load(5);
        t = 0;
        while (wa.size() < 2 && t < 40) begin cycle(); t++; end
        chk("t6_two_written", wa.size(), 2);
        #2 Rst_i = 1'b1;
        #1;
        chk("t6_rst_ready", CoeffReady_o, 0);
        chk("t6_rst_wr", CoeffWr_o, 0);
        chk("t6_rst_addr", CoeffAddr_o, 0);
        chk("t6_rst_cdata", CoeffData_o, 0);
        chk("t6_rst_nd", DataNdFwd_o, 0);
        chk("t6_rst_fwd", DataFwd_o, 0);
        chk("t6_rst_dv", DataValid_o, 0);
        chk("t6_rst_do", Data_o, 0);
        chk("t6_rst_busy", Busy_o, 0);
        chk("t6_rst_err", LoadErr_o, 0);
        chk("t6_rst_drop", DropCnt_o, 0);
        model_reset();
        repeat (2) cycle();
        Rst_i = 1'b0;
        clear_log();
        start_load(5);
        repeat (10) cycle();
        chk("t6_nwr", wa.size(), 5);
        for (int i = 0; i < 5 && i < wa.size(); i++) chk("t6_addr", wa[i], i);

        // Free-running random traffic with sporadic loads.
        nd_period = 0; cv_mode = 3;
        for (int i = 0; i < 1500; i++) begin
            Load_i = ($urandom_range(0, 39) == 0);
            LoadLen_i = AW'($urandom);
            cycle();
        end
        Load_i = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
